// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_arbiter.
// slave: the arbiter's view. master: the surrounding system (requesters plus UART).
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              uart_dat_we;
  logic [7:0]        uart_dat_di;
  logic              uart_dat_wait;

  modport master (
    output req_valid, req_data, uart_dat_wait,
    input  req_ready, uart_dat_we, uart_dat_di
  );

  modport slave (
    input  req_valid, req_data, uart_dat_wait,
    output req_ready, uart_dat_we, uart_dat_di
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit-data write port between NREQ requesters.
// Optional line-lock mode (keeps a requester's line together until '\n' or an idle
// timeout) is compiled in with `define UART_ARB_LINELOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 255,
  localparam int unsigned IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  uart_tx_arbiter_if.slave    bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy
);

  // Reject unsupported configurations at elaboration.
  if (NREQ < 2 || NREQ > 8 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255) begin : g_bad_params
    $error("uart_tx_arbiter: NREQ must be 2..8 and LOCK_TIMEOUT 1..255");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [7:0]      hold_q, hold_d;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     cand;
  logic [IW:0]     ptr_inc;
  logic [IW-1:0]   next_ptr;

`ifdef UART_ARB_LINELOCK_EN
  logic            lock_q, lock_d;
  logic [7:0]      lock_cnt_q, lock_cnt_d;
`endif

  // Requesters allowed to win this cycle; a held line restricts it to its owner.
  always_comb begin
    eligible = bus.req_valid;
`ifdef UART_ARB_LINELOCK_EN
    if (lock_q) begin
      eligible = bus.req_valid & (NREQ'(1) << grant_id_q);
    end
`endif
  end

  // First eligible requester searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(j);
      // Sum stays below 2*NREQ, so one subtraction is a full modulo.
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && eligible[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // Pointer to the requester after the current grant, wrapping at NREQ.
  always_comb begin
    ptr_inc  = {1'b0, grant_id_q} + (IW+1)'(1);
    next_ptr = (ptr_inc >= (IW+1)'(NREQ)) ? '0 : ptr_inc[IW-1:0];
  end

  // Next-state logic: grant in IDLE, wait for UART acceptance in SEND.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
`ifdef UART_ARB_LINELOCK_EN
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StSend;
          hold_d     = bus.req_data[8*pick +: 8];
          grant_id_d = pick;
`ifdef UART_ARB_LINELOCK_EN
          lock_d     = 1'b1;
          lock_cnt_d = '0;
`endif
        end
`ifdef UART_ARB_LINELOCK_EN
        else if (lock_q) begin
          // Owner has been silent; count idle cycles and give the line up at the limit.
          if (lock_cnt_q == 8'(LOCK_TIMEOUT - 1)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end
`endif
      end
      StSend: begin
        if (!bus.uart_dat_wait) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
`ifdef UART_ARB_LINELOCK_EN
          if (hold_q == 8'h0A) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; req_ready never depends on uart_dat_wait.
  always_comb begin
    bus.req_ready   = '0;
    bus.uart_dat_we = 1'b0;
    bus.uart_dat_di = 8'h00;
    busy            = 1'b0;
    unique case (state_q)
      StIdle: begin
        // No byte is taken while reset is being applied.
        if (found && resetn) begin
          bus.req_ready = NREQ'(1) << pick;
        end
      end
      StSend: begin
        bus.uart_dat_we = 1'b1;
        bus.uart_dat_di = hold_q;
        busy            = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_id = grant_id_q;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      hold_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
    end
  end

`ifdef UART_ARB_LINELOCK_EN
  // Line-lock flag and idle timeout counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle reference model plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ         = 4;
  localparam int unsigned LOCK_TIMEOUT = 255;
  localparam int unsigned IW           = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] grant_id;
  logic          busy;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  byte unsigned    src_q [NREQ][$];  // bytes each requester still has to send
  byte unsigned    rx_q [$];         // bytes the UART accepted
  logic [NREQ-1:0] rdy_seen;
  logic            wait_next;
  logic            rst_next;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: honour last cycle's ready pulses, drive inputs after the edge,
  // then sample outputs on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    rdy_seen          = '0;
    resetn            = rst_next;
    bus.uart_dat_wait = wait_next;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = (src_q[i].size() > 0);
      bus.req_data[8*i +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    @(negedge clk);
    rdy_seen = bus.req_ready;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Reference model: either waiting for a requester or carrying one byte to the UART.
  bit              m_on = 1'b0;
  bit              m_send;
  byte unsigned    m_byte;
  int              m_grant, m_ptr;
  bit              m_lock;
  int              m_low;
  logic [NREQ-1:0] e_rdy;
  logic            e_we;
  logic [7:0]      e_di;
  int              pick, c;

  always @(negedge clk) begin
    pick = -1;
    if (m_on) begin
      e_rdy = '0;
      e_we  = m_send;
      e_di  = m_send ? m_byte : 8'h00;
      if (!m_send) begin
        for (int j = 0; j < NREQ; j++) begin
          c = (m_ptr + j) % NREQ;
          if (pick < 0 && bus.req_valid[c] && (!m_lock || c == m_grant)) pick = c;
        end
        if (pick >= 0 && resetn) e_rdy[pick] = 1'b1;
      end
      tests++;
      if (bus.req_ready !== e_rdy || bus.uart_dat_we !== e_we || bus.uart_dat_di !== e_di ||
          grant_id !== IW'(m_grant) || busy !== m_send) begin
        fails++;
        $display("FAIL model_cycle @%0t: ready=%b/%b we=%b/%b di=%h/%h gid=%0d/%0d busy=%b/%b",
                 $time, bus.req_ready, e_rdy, bus.uart_dat_we, e_we, bus.uart_dat_di, e_di,
                 grant_id, m_grant, busy, m_send);
      end
      if (bus.uart_dat_we === 1'b1 && bus.uart_dat_wait === 1'b0) rx_q.push_back(bus.uart_dat_di);
    end
    // Advance the model across the coming rising edge.
    if (resetn === 1'b0) begin
      m_on = 1'b1; m_send = 1'b0; m_byte = 8'h00; m_grant = 0; m_ptr = 0;
      m_lock = 1'b0; m_low = 0;
    end else if (m_on) begin
      if (!m_send) begin
        if (pick >= 0) begin
          m_send  = 1'b1;
          m_byte  = bus.req_data[8*pick +: 8];
          m_grant = pick;
`ifdef UART_ARB_LINELOCK_EN
          m_lock  = 1'b1;
          m_low   = 0;
`endif
        end else if (m_lock) begin
          m_low++;
          if (m_low == LOCK_TIMEOUT) begin
            m_lock = 1'b0;
            m_low  = 0;
          end
        end
      end else if (!bus.uart_dat_wait) begin
        m_send = 1'b0;
        m_ptr  = (m_grant + 1) % NREQ;
        if (m_lock && m_byte == 8'h0A) m_lock = 1'b0;
      end
    end
  end

  int we_cnt, rdy_cnt, gap;

  initial begin
    rst_next  = 1'b0;
    wait_next = 1'b0;
    rdy_seen  = '0;
    run(3);
    check("reset_ready", bus.req_ready, 0);
    check("reset_we", bus.uart_dat_we, 0);
    check("reset_di", bus.uart_dat_di, 0);
    check("reset_busy", busy, 0);
    check("reset_grant_id", grant_id, 0);
    rst_next = 1'b1;
    tick();

    // Single requester 2, UART ready.
    src_q[2].push_back(8'h41);
    tick();
    check("single_ready", bus.req_ready, 4'b0100);
    check("single_we_t", bus.uart_dat_we, 0);
    tick();
    check("single_we_t1", bus.uart_dat_we, 1);
    check("single_di", bus.uart_dat_di, 8'h41);
    check("single_grant_id", grant_id, 2);
    check("single_ready_t1", bus.req_ready, 0);
    tick();
    check("single_we_t2", bus.uart_dat_we, 0);
    check("single_busy_t2", busy, 0);

`ifndef UART_ARB_LINELOCK_EN
    // UART busy for 20 cycles after the grant.
    rx_q.delete();
    we_cnt  = 0;
    rdy_cnt = 0;
    src_q[0].push_back(8'h55);
    for (int k = 0; k < 30; k++) begin
      wait_next = (k >= 1 && k <= 20);
      tick();
      if (bus.uart_dat_we) we_cnt++;
      if (bus.req_ready[0]) rdy_cnt++;
    end
    check("busy_we_cycles", we_cnt, 21);
    check("busy_accepts", rx_q.size(), 1);
    check("busy_byte", rx_q[0], 8'h55);
    check("busy_ready_pulses", rdy_cnt, 1);

    // Wrap-around: last grant 3, then requesters 1 and 3.
    wait_next = 1'b0;
    rx_q.delete();
    src_q[3].push_back(8'h33);
    run(4);
    check("wrap_last_grant", grant_id, 3);
    src_q[1].push_back(8'h21);
    src_q[3].push_back(8'h34);
    run(8);
    check("wrap_count", rx_q.size(), 3);
    check("wrap_first", rx_q[1], 8'h21);
    check("wrap_second", rx_q[2], 8'h34);

    // All four continuously valid.
    rx_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].push_back(8'(8'h10 + i));
      src_q[i].push_back(8'(8'h10 + i));
    end
    run(22);
    check("rr_count", rx_q.size(), 8);
    check("rr_0", rx_q[0], 8'h10);
    check("rr_1", rx_q[1], 8'h11);
    check("rr_2", rx_q[2], 8'h12);
    check("rr_3", rx_q[3], 8'h13);
    check("rr_4", rx_q[4], 8'h10);

    // Reset in the middle of a stalled send; pointer must come back to 0.
    rx_q.delete();
    src_q[0].push_back(8'h50);
    run(4);
    wait_next = 1'b1;
    src_q[2].push_back(8'hAA);
    tick();
    tick();
    check("rstmid_we_before", bus.uart_dat_we, 1);
    rst_next = 1'b0;
    tick();
    check("rstmid_we_in_reset_cycle", bus.uart_dat_we, 1);
    tick();
    check("rstmid_we_after", bus.uart_dat_we, 0);
    rst_next  = 1'b1;
    wait_next = 1'b0;
    src_q[1].push_back(8'h61);
    src_q[0].push_back(8'h60);
    tick();
    check("rstmid_first_grant", bus.req_ready, 4'b0001);
    run(6);
    check("rstmid_count", rx_q.size(), 3);
    check("rstmid_b0", rx_q[0], 8'h50);
    check("rstmid_b1", rx_q[1], 8'h60);
    check("rstmid_b2", rx_q[2], 8'h61);
`else
    // Line lock: "ab\n" from 0 is not interleaved with requester 1.
    rst_next = 1'b0;
    run(2);
    rst_next = 1'b1;
    rx_q.delete();
    src_q[0].push_back(8'h61);
    src_q[0].push_back(8'h62);
    src_q[0].push_back(8'h0A);
    src_q[1].push_back(8'h71);
    run(14);
    check("lock_count", rx_q.size(), 4);
    check("lock_b0", rx_q[0], 8'h61);
    check("lock_b1", rx_q[1], 8'h62);
    check("lock_b2", rx_q[2], 8'h0A);
    check("lock_b3", rx_q[3], 8'h71);

    // Line lock released after LOCK_TIMEOUT idle cycles of the owner.
    rst_next = 1'b0;
    run(2);
    rst_next = 1'b1;
    rx_q.delete();
    src_q[0].push_back(8'h78);
    src_q[1].push_back(8'h72);
    tick();
    check("timeout_first_grant", bus.req_ready, 4'b0001);
    gap = 0;
    for (int k = 0; k < 400 && !bus.req_ready[1]; k++) begin
      tick();
      gap++;
    end
    check("timeout_gap", gap, 257);
    run(4);
    check("timeout_count", rx_q.size(), 2);
    check("timeout_b1", rx_q[1], 8'h72);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
